// File: rtl/control_unit_pipelined.sv
// Decode-stage control unit: decodes RV32I opcode/funct3/funct7 into a control bundle
// and registers it into the ID/EX boundary, flagging and counting illegal encodings.
// Latency: 1 cycle decode->execute. Backpressure: stall_e holds ID/EX, flush_e inserts a bubble.
module control_unit_pipelined #(
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_d,
  input  logic [6:0]            opcode_d,
  input  logic [2:0]            funct3_d,
  input  logic [6:0]            funct7_d,
  input  logic                  stall_e,
  input  logic                  flush_e,
  output logic                  valid_e,
  output logic                  RegWrite_e,
  output logic                  MemWrite_e,
  output logic                  Branch_e,
  output logic                  Jump_e,
  output logic                  ALUSrc_e,
  output logic [1:0]            ResultSrc_e,
  output logic [2:0]            ImmSrc_e,
  output logic [ALU_CTRL_W-1:0] ALUControl_e,
  output logic [2:0]            funct3_e,
  output logic                  illegal_e,
  output logic [CNT_W-1:0]      illegal_count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_t;

  ctrl_t            dec;
  ctrl_t            ex_d, ex_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Base ALU operation selected by funct3 (before funct7 alternates).
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_from_f3 = ALU_ADD;
      3'b001:  alu_from_f3 = ALU_SLL;
      3'b010:  alu_from_f3 = ALU_SLT;
      3'b011:  alu_from_f3 = ALU_SLTU;
      3'b100:  alu_from_f3 = ALU_XOR;
      3'b101:  alu_from_f3 = ALU_SRL;
      3'b110:  alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

  // Combinational decode of the incoming instruction fields.
  always_comb begin
    dec        = '0;
    dec.valid  = valid_d;
    dec.funct3 = funct3_d;
    case (opcode_d)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_from_f3(funct3_d);
        if (funct7_d == F7_ALT) begin
          if (funct3_d == 3'b000)      dec.alu_ctrl = ALU_SUB;
          else if (funct3_d == 3'b101) dec.alu_ctrl = ALU_SRA;
          else                         dec.illegal  = 1'b1;
        end else if (funct7_d != F7_ZERO) begin
          dec.illegal = 1'b1;
        end
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = alu_from_f3(funct3_d);
        if (funct3_d == 3'b101 && funct7_d[5]) dec.alu_ctrl = ALU_SRA;
        // Shift-immediate encodings carry a funct7 that must be well formed.
        if (funct3_d == 3'b001 && funct7_d != F7_ZERO) dec.illegal = 1'b1;
        if (funct3_d == 3'b101 && funct7_d != F7_ZERO && funct7_d != F7_ALT) dec.illegal = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'b001;
      end
      OP_BR: begin
        dec.branch   = 1'b1;
        dec.imm_src  = 3'b010;
        dec.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.imm_src    = 3'b011;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'b100;
        dec.alu_ctrl  = ALU_PASSB;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal instructions must never produce architectural side effects.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
    // A bubble from decode carries no enables and no illegal flag.
    if (!valid_d) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.illegal   = 1'b0;
    end
  end

  // Next-state for the ID/EX register and illegal counter; flush beats stall.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush_e) begin
      ex_d = '0;
    end else if (!stall_e) begin
      ex_d = dec;
      if (dec.illegal && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ID/EX state register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_e       = ex_q.valid;
  assign RegWrite_e    = ex_q.reg_write;
  assign MemWrite_e    = ex_q.mem_write;
  assign Branch_e      = ex_q.branch;
  assign Jump_e        = ex_q.jump;
  assign ALUSrc_e      = ex_q.alu_src;
  assign ResultSrc_e   = ex_q.result_src;
  assign ImmSrc_e      = ex_q.imm_src;
  assign ALUControl_e  = ALU_CTRL_W'(ex_q.alu_ctrl);
  assign funct3_e      = ex_q.funct3;
  assign illegal_e     = ex_q.illegal;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_control_unit_pipelined.sv
// Self-checking bench for control_unit_pipelined: directed vector table plus
// randomized traffic against a behavioural model; a second instance uses CNT_W=2.
module tb_control_unit_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid_d, stall_e, flush_e;
  logic [6:0] opcode_d, funct7_d;
  logic [2:0] funct3_d;

  logic       valid_e, RegWrite_e, MemWrite_e, Branch_e, Jump_e, ALUSrc_e, illegal_e;
  logic [1:0] ResultSrc_e;
  logic [2:0] ImmSrc_e, funct3_e;
  logic [3:0] ALUControl_e;
  logic [7:0] illegal_count;

  logic       valid_e2, RegWrite_e2, MemWrite_e2, Branch_e2, Jump_e2, ALUSrc_e2, illegal_e2;
  logic [1:0] ResultSrc_e2;
  logic [2:0] ImmSrc_e2, funct3_e2;
  logic [3:0] ALUControl_e2;
  logic [1:0] illegal_count2;

  control_unit_pipelined #(.ALU_CTRL_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .opcode_d(opcode_d), .funct3_d(funct3_d),
    .funct7_d(funct7_d), .stall_e(stall_e), .flush_e(flush_e), .valid_e(valid_e),
    .RegWrite_e(RegWrite_e), .MemWrite_e(MemWrite_e), .Branch_e(Branch_e), .Jump_e(Jump_e),
    .ALUSrc_e(ALUSrc_e), .ResultSrc_e(ResultSrc_e), .ImmSrc_e(ImmSrc_e),
    .ALUControl_e(ALUControl_e), .funct3_e(funct3_e), .illegal_e(illegal_e),
    .illegal_count(illegal_count)
  );

  control_unit_pipelined #(.ALU_CTRL_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .valid_d(valid_d), .opcode_d(opcode_d), .funct3_d(funct3_d),
    .funct7_d(funct7_d), .stall_e(stall_e), .flush_e(flush_e), .valid_e(valid_e2),
    .RegWrite_e(RegWrite_e2), .MemWrite_e(MemWrite_e2), .Branch_e(Branch_e2), .Jump_e(Jump_e2),
    .ALUSrc_e(ALUSrc_e2), .ResultSrc_e(ResultSrc_e2), .ImmSrc_e(ImmSrc_e2),
    .ALUControl_e(ALUControl_e2), .funct3_e(funct3_e2), .illegal_e(illegal_e2),
    .illegal_count(illegal_count2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected ID/EX contents, in plain integers.
  typedef struct {
    int v, rw, mw, br, j, src, rs, imm, alu, f3, ill;
  } exp_t;

  typedef struct {
    int rst, vld, op, f3, f7, stall, flush;
    int v, rw, mw, br, j, src, rs, imm, alu, ef3, ill, cnt, cnt2;
  } vec_t;

  vec_t tbl[$];
  int   f3_alu[8];

  task automatic check_outputs(input string tag, input exp_t e, input int cnt, input int cnt2);
    chk({tag, ".valid_e"},      32'(valid_e),       32'(e.v));
    chk({tag, ".RegWrite_e"},   32'(RegWrite_e),    32'(e.rw));
    chk({tag, ".MemWrite_e"},   32'(MemWrite_e),    32'(e.mw));
    chk({tag, ".Branch_e"},     32'(Branch_e),      32'(e.br));
    chk({tag, ".Jump_e"},       32'(Jump_e),        32'(e.j));
    chk({tag, ".ALUSrc_e"},     32'(ALUSrc_e),      32'(e.src));
    chk({tag, ".ResultSrc_e"},  32'(ResultSrc_e),   32'(e.rs));
    chk({tag, ".ImmSrc_e"},     32'(ImmSrc_e),      32'(e.imm));
    chk({tag, ".ALUControl_e"}, 32'(ALUControl_e),  32'(e.alu));
    chk({tag, ".funct3_e"},     32'(funct3_e),      32'(e.f3));
    chk({tag, ".illegal_e"},    32'(illegal_e),     32'(e.ill));
    chk({tag, ".illegal_count"}, 32'(illegal_count), 32'(cnt));
    chk({tag, ".valid_e(c2)"},  32'(valid_e2),      32'(e.v));
    chk({tag, ".illegal_e(c2)"}, 32'(illegal_e2),   32'(e.ill));
    chk({tag, ".illegal_count(c2)"}, 32'(illegal_count2), 32'(cnt2));
  endtask

  // Reference decode straight from the instruction-class rules.
  function automatic exp_t ref_decode(input int op, input int f3, input int f7);
    exp_t e;
    e = '{default: 0};
    e.f3 = f3;
    case (op)
      'h33: begin
        e.rw = 1; e.alu = f3_alu[f3];
        if (f7 == 'h20) begin
          if (f3 == 0)      e.alu = 1;
          else if (f3 == 5) e.alu = 9;
          else              e.ill = 1;
        end else if (f7 != 0) e.ill = 1;
      end
      'h13: begin
        e.rw = 1; e.src = 1; e.alu = f3_alu[f3];
        if (f3 == 5 && (f7 & 'h20) != 0) e.alu = 9;
        if (f3 == 1 && f7 != 0) e.ill = 1;
        if (f3 == 5 && f7 != 0 && f7 != 'h20) e.ill = 1;
      end
      'h03: begin e.rw = 1; e.src = 1; e.rs = 1; end
      'h23: begin e.mw = 1; e.src = 1; e.imm = 1; end
      'h63: begin e.br = 1; e.imm = 2; e.alu = 1; end
      'h6F: begin e.rw = 1; e.j = 1; e.rs = 2; e.imm = 3; end
      'h37: begin e.rw = 1; e.src = 1; e.imm = 4; e.alu = 10; end
      default: e.ill = 1;
    endcase
    if (e.ill != 0) begin e.rw = 0; e.mw = 0; e.br = 0; e.j = 0; end
    return e;
  endfunction

  exp_t m_exp;
  int   m_cnt, m_cnt2;

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    exp_t d;
    if (rst) begin
      m_exp = '{default: 0}; m_cnt = 0; m_cnt2 = 0;
    end else if (flush_e) begin
      m_exp = '{default: 0};
    end else if (!stall_e) begin
      d = ref_decode(int'(opcode_d), int'(funct3_d), int'(funct7_d));
      d.v = int'(valid_d);
      if (!valid_d) begin d.rw = 0; d.mw = 0; d.br = 0; d.j = 0; d.ill = 0; end
      else if (d.ill != 0) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_exp = d;
    end
  endtask

  task automatic drive(input int r, input int vld, input int op, input int f3, input int f7,
                       input int st, input int fl);
    rst = r[0]; valid_d = vld[0]; opcode_d = op[6:0]; funct3_d = f3[2:0];
    funct7_d = f7[6:0]; stall_e = st[0]; flush_e = fl[0];
  endtask

  initial begin
    exp_t e;
    vec_t t;
    int   op_list[7];
    f3_alu = '{0, 7, 5, 6, 4, 8, 3, 2};
    op_list = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h6F, 'h37};
    drive(1, 0, 0, 0, 0, 0, 0);

    //           rst vld op    f3 f7    st fl  v rw mw br j src rs imm alu f3 ill cnt c2
    tbl.push_back('{1, 0, 'h00, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 'h00, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 'h00, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 'h33, 0, 'h20, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 'h33, 0, 'h00, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 'h03, 2, 'h00, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0, 0});
    tbl.push_back('{0, 1, 'h23, 2, 'h00, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0});
    tbl.push_back('{0, 1, 'h63, 1, 'h00, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 1, 'h6F, 0, 'h00, 0, 0, 1, 1, 0, 0, 1, 0, 2, 3, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 'h37, 0, 'h00, 0, 0, 1, 1, 0, 0, 0, 1, 0, 4, 10, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 'h03, 2, 'h00, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0, 0});
    for (int k = 0; k < 3; k++)
      tbl.push_back('{0, 1, 'h23, 2, 'h00, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0, 0});
    tbl.push_back('{0, 1, 'h23, 2, 'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 'h7F, 0, 'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1});
    tbl.push_back('{0, 0, 'h7F, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{0, 1, 'h7F, 0, 'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2});
    tbl.push_back('{0, 1, 'h7F, 0, 'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3});
    tbl.push_back('{0, 1, 'h7F, 0, 'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 3});
    tbl.push_back('{0, 1, 'h7F, 0, 'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 3});
    tbl.push_back('{0, 1, 'h7F, 0, 'h00, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 3});
    tbl.push_back('{0, 1, 'h7F, 0, 'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 3});
    tbl.push_back('{0, 1, 'h13, 5, 'h20, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 9, 5, 0, 5, 3});
    tbl.push_back('{0, 1, 'h13, 1, 'h20, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 7, 1, 1, 6, 3});
    tbl.push_back('{0, 1, 'h33, 2, 'h20, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 2, 1, 7, 3});
    tbl.push_back('{1, 1, 'h03, 2, 'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 'h13, 0, 'h7F, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});

    foreach (tbl[i]) begin
      t = tbl[i];
      drive(t.rst, t.vld, t.op, t.f3, t.f7, t.stall, t.flush);
      @(posedge clk);
      #1;
      e = '{t.v, t.rw, t.mw, t.br, t.j, t.src, t.rs, t.imm, t.alu, t.ef3, t.ill};
      check_outputs($sformatf("row%0d", i), e, t.cnt, t.cnt2);
    end

    // Randomized traffic against the behavioural model, starting from reset.
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("rnd_reset", m_exp, m_cnt, m_cnt2);
    for (int c = 0; c < 3000; c++) begin
      int op, f7, sel;
      sel = int'($urandom_range(0, 9));
      op  = (sel < 7) ? op_list[sel] : int'($urandom_range(0, 127));
      sel = int'($urandom_range(0, 9));
      f7  = (sel < 5) ? 0 : (sel < 8) ? 'h20 : int'($urandom_range(0, 127));
      drive(($urandom_range(0, 199) == 0) ? 1 : 0,
            ($urandom_range(0, 99) < 85) ? 1 : 0,
            op, int'($urandom_range(0, 7)), f7,
            ($urandom_range(0, 99) < 15) ? 1 : 0,
            ($urandom_range(0, 99) < 10) ? 1 : 0);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs($sformatf("rnd%0d", c), m_exp, m_cnt, m_cnt2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
